// File: rtl/ws2812b_frame_reader_if.sv
// Frame-reader bus: trigger/status handshake, BRAM read port and LED data line.
interface ws2812b_frame_reader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_read;
    logic [DATA_WIDTH-1:0] bram_data;
    logic                  dout;

    modport master (
        input  start, bram_data,
        output busy, done, bram_addr, bram_read, dout
    );

    modport slave (
        output start, bram_data,
        input  busy, done, bram_addr, bram_read, dout
    );
endinterface

// File: rtl/ws2812b_frame_reader.sv
// Scans the frame-buffer BRAM and serialises each pixel onto a WS2812B line.
// Define FRAME_AUTO_REFRESH_EN to restart frames continuously after the first start.
module ws2812b_frame_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_LEDS   = 64,
    parameter int T0H_CYC    = 35,
    parameter int T1H_CYC    = 70,
    parameter int BIT_CYC    = 125,
    parameter int LATCH_CYC  = 5000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ws2812b_frame_reader_if.master bus
);
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = $clog2(LATCH_CYC + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_LATCH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] pf_q, pf_d;
    logic                  rd_dly_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  read_d, dout_d, busy_d, done_d;
    logic                  go;
    int                    hi_cyc;

`ifdef FRAME_AUTO_REFRESH_EN
    logic auto_q, auto_d;
    assign go = bus.start | auto_q;
`else
    assign go = bus.start;
`endif

    assign hi_cyc = shreg_q[DATA_WIDTH-1] ? T1H_CYC : T0H_CYC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        lat_d   = lat_q;
        shreg_d = shreg_q;
        pf_d    = pf_q;
        addr_d  = bus.bram_addr;
        read_d  = 1'b0;
        dout_d  = 1'b0;
        busy_d  = bus.busy;
        done_d  = 1'b0;
`ifdef FRAME_AUTO_REFRESH_EN
        auto_d  = auto_q;
`endif
        // Read data is valid two edges after the strobe was registered.
        if (rd_dly_q) pf_d = bus.bram_data;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    read_d  = 1'b1;
`ifdef FRAME_AUTO_REFRESH_EN
                    auto_d  = 1'b1;
`endif
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_SEND;
                shreg_d = bus.bram_data;
                pix_d   = '0;
                cyc_d   = '0;
                bit_d   = '0;
                dout_d  = 1'b1;
                if (PIX_LAST != '0) begin
                    addr_d = ADDR_WIDTH'(1);
                    read_d = 1'b1;
                end
            end
            S_SEND: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (pix_q == PIX_LAST) begin
                            state_d = S_LATCH;
                            lat_d   = '0;
                        end else begin
                            // Next pixel starts seamlessly from the prefetched word.
                            shreg_d = pf_q;
                            pix_d   = pix_q + PW'(1);
                            dout_d  = 1'b1;
                            if (pix_q + PW'(1) < PIX_LAST) begin
                                addr_d = ADDR_WIDTH'(pix_q + PW'(2));
                                read_d = 1'b1;
                            end
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_q << 1;
                        dout_d  = 1'b1;
                    end
                end else begin
                    cyc_d  = cyc_q + CW'(1);
                    dout_d = (int'(cyc_q) + 1) < hi_cyc;
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef FRAME_AUTO_REFRESH_EN
                    busy_d  = 1'b1;
`else
                    busy_d  = 1'b0;
`endif
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q         <= '0;
            bit_q         <= '0;
            pix_q         <= '0;
            lat_q         <= '0;
            shreg_q       <= '0;
            pf_q          <= '0;
            rd_dly_q      <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_read <= 1'b0;
            bus.dout      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            cyc_q         <= cyc_d;
            bit_q         <= bit_d;
            pix_q         <= pix_d;
            lat_q         <= lat_d;
            shreg_q       <= shreg_d;
            pf_q          <= pf_d;
            rd_dly_q      <= bus.bram_read;
            bus.bram_addr <= addr_d;
            bus.bram_read <= read_d;
            bus.dout      <= dout_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
        end
    end

`ifdef FRAME_AUTO_REFRESH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_q <= 1'b0;
        else        auto_q <= auto_d;
    end
`endif
endmodule

// File: doc/ws2812b_frame_reader.md
# ws2812b_frame_reader

Frame-buffer reader and WS2812B line driver. It scans the LED frame buffer BRAM through that memory's registered read port, one pixel word per LED. It serialises each word onto the single-wire WS2812B data line with no gap between pixels, then holds the line low for the latch period. It sits between the frame-buffer BRAM read port and the LED-strip output pin, and is triggered per frame by the display controller.

## Interface
- DATA_WIDTH, 24: bits per pixel word, sent MSB first.
- ADDR_WIDTH, 8: BRAM address width.
- NUM_LEDS, 64: pixels per frame, 1..2**ADDR_WIDTH.
- T0H_CYC, 35: clk cycles high for a 0 bit.
- T1H_CYC, 70: clk cycles high for a 1 bit.
- BIT_CYC, 125: clk cycles per bit. Constraint: T0H_CYC < T1H_CYC < BIT_CYC.
- LATCH_CYC, 5000: clk cycles low after the last bit.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- busy  out  1  high from the edge start is accepted until the frame completes.
- done  out  1  one-cycle pulse at frame completion.
- bram_addr  out  ADDR_WIDTH  read address to the BRAM, registered.
- bram_read  out  1  read strobe, registered.
- bram_data  in  DATA_WIDTH  BRAM registered read data. Valid one edge after bram_addr is sampled.
- dout  out  1  WS2812B data line.

## Operation
- Reset values: busy=0, done=0, bram_addr=0, bram_read=0, dout=0, state IDLE. Reset applies asynchronously, including mid-frame; dout drops low immediately.
- IDLE: if start=1, the next state is FETCH, busy=1, bram_addr=0 and bram_read=1. start while busy is ignored, not queued.
- FETCH → WAIT (BRAM samples the address) → LOAD. In LOAD, bram_data is captured into the shift register, the pixel index is 0, and SEND begins.
- SEND: each bit lasts BIT_CYC cycles. dout is high for T1H_CYC cycles if the bit is 1, else T0H_CYC cycles, then low for the rest of the bit period. A bit counter and a cycle counter control sequencing.
- Prefetch: during the first bit of pixel i (i < NUM_LEDS-1), issue bram_addr=i+1 with a one-cycle bram_read pulse. Capture the result into a prefetch register 2 cycles later. At the end of the last bit of pixel i, transfer the prefetch register to the shift register. There is zero idle time between pixels.
- No read is issued beyond NUM_LEDS-1, and addresses never wrap.
- After the last bit of pixel NUM_LEDS-1, enter LATCH: dout=0 for LATCH_CYC cycles, then go to IDLE with done=1 and busy=0 in the same cycle.
- A start pulse that is high in the done cycle is accepted, because the state is already IDLE.
- bram_read is high only on cycles that carry a new address.

## Timing
- start sampled at edge N → bram_addr=0 and bram_read=1 from N. The BRAM samples at N+1. The shift register loads and dout rises at N+2.
- Frame length from the first dout rise to the done pulse: NUM_LEDS·DATA_WIDTH·BIT_CYC + LATCH_CYC cycles.
- Each rising edge of dout is exactly BIT_CYC cycles after the previous one within a frame.
- dout is registered, so there are no combinational glitches.

## Configuration
- FRAME_AUTO_REFRESH_EN defined: after LATCH, the block pulses done for one cycle and re-enters FETCH at address 0 without waiting for start. busy stays high continuously, and start is ignored after the first frame. Only reset stops refresh.
- Not defined: single-shot frames as described in Operation.

## Test plan
Test parameters: BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, LATCH_CYC=40, NUM_LEDS=4, DATA_WIDTH=24. The BRAM model holds 0xFF0000, 0x00FF00, 0x0000FF, 0xA5A5A5.
- Single frame: start at edge N → dout rises at N+2. The decoded high widths give 96 bits matching the four words. done pulses exactly 96·10+40 = 1000 cycles after the first rise.
- Pixel boundary: the rising-edge spacing is 10 cycles everywhere, including across pixels 0→1, 1→2 and 2→3. bram_read pulses exactly 4 times per frame with addresses 0,1,2,3.
- start during busy at cycle 500 → ignored. The next frame starts only from a start pulse in or after the done cycle.
- rst_n low at cycle 300 mid-bit → dout=0, busy=0 and bram_read=0 immediately. After release, start gives a clean frame from address 0.
- start held high through the done cycle → a second frame begins with no idle cycle beyond IDLE acceptance.
- With FRAME_AUTO_REFRESH_EN: one start → done pulses every 1000+3 cycles, and busy never falls across 3 frames.
